bit_serial_adder: RTL
=====================

Name: bit_serial_adder

Overview:
- Multi-bit adder built on the team's 1-bit full adder cell `full_add` (ports a, b, ci, so, co). It sits directly upstream of that cell.
- Accepts two WIDTH-bit operands plus a carry-in through a valid/ready handshake. It feeds the full adder one bit pair per clock, LSB first, and keeps the running carry in a flop.
- Collects the sum bits in a shift register and presents sum and carry-out through an output valid/ready handshake.
- Target: small-area arithmetic where one adder cell per datapath is preferred over a ripple array.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk
- in_valid  input  1  operands and cin are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- cin  input  1  carry-in for bit 0
- out_valid  output  1  sum/cout hold a completed result
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result bits; meaningful only while out_valid=1
- cout  output  1  carry out of bit WIDTH-1; meaningful only while out_valid=1
- busy  output  1  high in RUN and DONE

Behaviour:
- Reset (rst=1 at an edge):
  - state<=IDLE; shift registers A, B and S<=0; carry<=0; cnt<=0.
  - Resulting outputs: out_valid=0, sum=0, cout=0, busy=0, in_ready=1.
  - rst has priority over every other input, including mid-RUN and mid-DONE; any partial result is discarded.
- Output decoding: all outputs decode from registered state or datapath, with no combinational input-to-output paths.
  - in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE).
  - sum = S; cout = carry.
- IDLE:
  - On in_valid=1 at an edge: A<=op_a, B<=op_b, carry<=cin, S<=0, cnt<=0, then go to RUN.
  - Otherwise hold.
- RUN: one bit per cycle.
  - The full adder inputs are a=A[0], b=B[0], ci=carry.
  - Each edge: A<=A>>1, B<=B>>1, S<={so, S[WIDTH-1:1]}, carry<=co, cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1, go to DONE. RUN therefore lasts exactly WIDTH cycles.
  - in_valid and operand changes are ignored during RUN; in_ready=0.
- DONE:
  - out_valid=1; S and carry are frozen.
  - On out_ready=1 at an edge, go to IDLE. Otherwise hold indefinitely (backpressure).
- Latency:
  - Operands accepted at edge E0 give out_valid=1 from edge E0+WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles: WIDTH in RUN, at least 1 in DONE, 1 in IDLE.
- Simultaneous events:
  - out_ready and in_valid both high while in DONE: the result is consumed and the new operands are NOT taken, because in_ready=0.
  - The new operands are accepted on the next edge in IDLE if in_valid is still high.
- After return to IDLE, S and carry keep the last result until the next acceptance; consumers must qualify on out_valid.
- Counter: cnt is max(1,$clog2(WIDTH)) bits wide and never wraps within a transaction.
- Arithmetic: {cout,sum} = op_a + op_b + cin, exact with no truncation; the result is WIDTH+1 bits.

Test Plan:
- WIDTH=8: op_a=0x5A, op_b=0x3C, cin=0, out_ready=1 -> out_valid rises 8 edges after acceptance; sum=0x96, cout=0; out_valid high for exactly 1 cycle.
- 0xFF+0x01, cin=0 -> sum=0x00, cout=1; then 0xFF+0xFF, cin=1 -> sum=0xFF, cout=1; then 0x00+0x00, cin=1 -> sum=0x01, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum/cout/out_valid stable all 5 cycles; out_ready=1 gives IDLE next cycle with in_ready=1.
- Ignore during RUN: pulse in_valid with different operands at cycle 3 of RUN (0x12+0x34 in flight) -> result still 0x46, cout=0; in_ready=0 throughout RUN/DONE.
- Reset mid-RUN: assert rst for 1 cycle at RUN cycle 4 -> next cycle state IDLE, in_ready=1, out_valid=0, sum=0, cout=0; a following 0x01+0x01 gives 0x02.
- Random regression with WIDTH=8 and WIDTH=16: 1000 back-to-back transactions with random in_valid/out_ready gaps -> every {cout,sum} matches op_a+op_b+cin; no transaction is lost or duplicated.

Source files
------------

// File: rtl/bit_serial_adder_if.sv
// Handshake bundle for bit_serial_adder: operand request side and result side.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry it; the interface adds no storage.
interface bit_serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   // Producer/consumer side (drives operands, accepts results).
   modport master (
      output in_valid, op_a, op_b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   // Adder side.
   modport slave (
      input  in_valid, op_a, op_b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_add cell fed LSB first, carry held in a flop.
// Latency: result valid WIDTH cycles after the operand handshake.
// Backpressure: holds the result in DONE until out_ready; in_ready only while IDLE.

// One-bit full adder cell.
module full_add (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic so,
   output logic co
);
   assign so = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   bit_serial_adder_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fa_so;
   logic             fa_co;
   logic             last_bit;

   // The single adder cell always sees the current LSBs and the running carry.
   full_add u_fa (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .ci (carry_q),
      .so (fa_so),
      .co (fa_co)
   );

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   // Next-state and datapath update; everything holds unless the state says otherwise.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.op_a;
               b_d     = bus.op_b;
               carry_d = bus.cin;
               s_d     = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            s_d     = {fa_so, s_q[WIDTH-1:1]};
            carry_d = fa_co;
            // Counter parks on the last index so it cannot wrap for power-of-two widths.
            if (last_bit) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset taking priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs come straight from registers; no input reaches an output combinationally.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.sum       = s_q;
   assign bus.cout      = carry_q;
endmodule
